// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle fp16 divider, quot = opA / opB.
// Scales a vertex delta by its out-degree in the graph-update datapath.
// Shares the adder's operand conventions: exponent 0 is read as exponent 1
// with no implicit one, exponent 31 is an ordinary value (no NaN/Inf), and
// results are rounded by adding the guard bit.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   in_valid     operands present on opA/opB
//   in_ready     idle, an operand pair will be accepted
//   opA, opB     fp16 dividend / divisor
//   out_valid    result held on quot/div_by_zero
//   out_ready    consumer accepts the result
//   quot         fp16 quotient
//   div_by_zero  divisor magnitude was zero for this result
module fp_div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quot,
  output logic        div_by_zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [15:0]        r_quot;
  logic               r_dbz;
  logic               r_sign;
  logic [10:0]        r_ma;
  logic [10:0]        r_mb;
  logic signed [6:0]  r_ea;
  logic signed [6:0]  r_eb;
  logic [11:0]        r_rem;
  logic [12:0]        r_q;
  logic [3:0]         r_cnt;

  // Round the 13-bit quotient (q[12] = integer bit), then saturate or flush.
  function automatic logic [15:0] f_round_pack(input logic sgn,
                                               input logic signed [6:0] e_base,
                                               input logic [12:0] q);
    logic signed [6:0] e;
    logic [11:0]       m;
    logic              g;
    if (q[12]) begin
      m = {1'b0, q[12:2]};
      g = q[1];
      e = e_base;
    end else begin
      m = {1'b0, q[11:1]};
      g = q[0];
      e = e_base - 7'sd1;
    end
    m = m + {11'd0, g};
    // Rounding carried out of the 11-bit mantissa: renormalise.
    if (m[11]) begin
      m = 12'd1024;
      e = e + 7'sd1;
    end
    if (e >= 7'sd31)
      return {sgn, 5'h1f, 10'h000};
    else if (e <= 7'sd0)
      return {sgn, 15'h0000};
    else
      return {sgn, e[4:0], m[9:0]};
  endfunction

  // Operand unpack: zero exponent reads as 1 with no implicit one.
  logic [10:0]       w_ma_in;
  logic [10:0]       w_mb_in;
  logic signed [6:0] w_ea_in;
  logic signed [6:0] w_eb_in;
  logic              w_sign_in;

  assign w_sign_in = opA[15] ^ opB[15];
  assign w_ma_in   = {|opA[14:10], opA[9:0]};
  assign w_mb_in   = {|opB[14:10], opB[9:0]};
  assign w_ea_in   = (opA[14:10] == 5'd0) ? 7'sd1 : $signed({2'b00, opA[14:10]});
  assign w_eb_in   = (opB[14:10] == 5'd0) ? 7'sd1 : $signed({2'b00, opB[14:10]});

  // Normalisation step: shift each mantissa whose MSB is still clear.
  logic [10:0]       w_ma_sh;
  logic [10:0]       w_mb_sh;
  logic signed [6:0] w_ea_sh;
  logic signed [6:0] w_eb_sh;
  logic              w_norm_done;

  assign w_ma_sh     = r_ma[10] ? r_ma : {r_ma[9:0], 1'b0};
  assign w_mb_sh     = r_mb[10] ? r_mb : {r_mb[9:0], 1'b0};
  assign w_ea_sh     = r_ma[10] ? r_ea : r_ea - 7'sd1;
  assign w_eb_sh     = r_mb[10] ? r_mb[10] ? r_eb : r_eb : r_eb - 7'sd1;
  assign w_norm_done = w_ma_sh[10] & w_mb_sh[10];

  // Restoring-division step. After subtraction rem < mB < 2048, so the
  // left shift never loses a set bit.
  logic        w_ge;
  logic [11:0] w_rem_sub;
  logic [11:0] w_rem_nx;

  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_nx  = w_rem_sub << 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= 16'h0000;
      r_dbz       <= 1'b0;
      r_sign      <= 1'b0;
      r_ma        <= 11'd0;
      r_mb        <= 11'd0;
      r_ea        <= 7'sd0;
      r_eb        <= 7'sd0;
      r_rem       <= 12'd0;
      r_q         <= 13'd0;
      r_cnt       <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign     <= w_sign_in;
            r_in_ready <= 1'b0;
            if (opB[14:0] == 15'd0) begin
              // Divide by zero wins over a zero dividend.
              r_quot      <= {w_sign_in, 5'h1f, 10'h000};
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (opA[14:0] == 15'd0) begin
              r_quot      <= {w_sign_in, 15'h0000};
              r_dbz       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_ma    <= w_ma_in;
              r_mb    <= w_mb_in;
              r_ea    <= w_ea_in;
              r_eb    <= w_eb_in;
              r_state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          r_ma <= w_ma_sh;
          r_mb <= w_mb_sh;
          r_ea <= w_ea_sh;
          r_eb <= w_eb_sh;
          if (w_norm_done) begin
            r_rem   <= {1'b0, w_ma_sh};
            r_q     <= 13'd0;
            r_cnt   <= 4'd0;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_q   <= {r_q[11:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd12)
            r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_quot      <= f_round_pack(r_sign, r_ea - r_eb + 7'sd15, r_q);
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quot        = r_quot;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed testbench for fp_div_seq with hand-computed
// quotients, latencies, backpressure and mid-operation reset.
module tb_fp_div_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fp_div_seq dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opA         (opA),
    .opB         (opB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then scramble them so that any
  // sampling outside the accept edge would corrupt the result.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    opA      = a;
    opB      = b;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    opA      = 16'hdead;
    opB      = 16'hbeef;
  endtask

  // Edges after the accept edge until out_valid is seen (0 = visible right
  // after the accept edge).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic edz, input int elat,
                        input logic early);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    chk({tag, "_rdy"}, in_ready, 1);
    out_ready = early;
    start(a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quot, eq);
    chk({tag, "_dz"}, div_by_zero, edz);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, "_vld0"}, out_valid, 0);
    chk({tag, "_rdy1"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opA       = 16'h0000;
    opB       = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 16'h0000);
    chk("rst_dz", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Exact, rounded, signed, special and range-edge quotients.
    run_op("one",      16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 15, 1'b0);
    run_op("frac",     16'h4200, 16'h4000, 16'h3E00, 1'b0, 15, 1'b0);
    run_op("third",    16'h3C00, 16'h4200, 16'h3555, 1'b0, 15, 1'b0);
    run_op("negthird", 16'hBC00, 16'h4200, 16'hB555, 1'b0, 15, 1'b1);
    run_op("rnd_up",   16'h3C01, 16'h4200, 16'h3557, 1'b0, 15, 1'b0);
    run_op("dz_neg",   16'hBC00, 16'h0000, 16'hFC00, 1'b1, 0,  1'b0);
    run_op("dz_zero",  16'h0000, 16'h0000, 16'h7C00, 1'b1, 0,  1'b0);
    run_op("zero_a",   16'h8000, 16'h3C00, 16'h8000, 1'b0, 0,  1'b1);
    run_op("sub",      16'h0001, 16'h0400, 16'h1400, 1'b0, 24, 1'b0);
    run_op("ovf",      16'h7BFF, 16'h0001, 16'h7C00, 1'b0, 24, 1'b0);
    run_op("unf",      16'h0400, 16'h7BFF, 16'h0000, 1'b0, 15, 1'b0);

    // Backpressure: result held for 5 cycles with out_ready low.
    out_ready = 1'b0;
    start(16'h4200, 16'h4000);
    wait_valid(lat);
    chk("bp_lat", lat, 15);
    for (int i = 0; i < 5; i++) begin
      chk("bp_q", quot, 16'h3E00);
      chk("bp_vld", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("bp_rdy_after", in_ready, 1);
    chk("bp_vld_after", out_valid, 0);
    run_op("b2b", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 15, 1'b0);

    // Reset in the middle of DIV discards the operation.
    start(16'h3C00, 16'h4200);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_quot", quot, 16'h0000);
    run_op("post_rst", 16'h4200, 16'h4000, 16'h3E00, 1'b0, 15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
